// File: rtl/dsp_pkg.sv
// Shared definitions for blocks on the DSP data-memory bus: bus widths,
// block-move modes and the copy-engine state encoding.
package dsp_pkg;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 16;
  localparam int DMEM_LW = DMEM_AW + 1;

  localparam logic DMA_COPY = 1'b0;
  localparam logic DMA_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } dma_state_t;

  // Word pointers wrap 0xFF -> 0x00 by plain truncation.
  function automatic logic [DMEM_AW-1:0] ptr_inc(input logic [DMEM_AW-1:0] p);
    return p + DMEM_AW'(1);
  endfunction

endpackage

// File: rtl/dmem_copy_engine.sv
// Block-move engine driving the data-memory port: copies a run of words from
// one address range to another, or fills a range with a constant.
module dmem_copy_engine
  import dsp_pkg::*;
#(
  parameter int READ_LAT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [DMEM_AW-1:0] src_addr,
  input  logic [DMEM_AW-1:0] dst_addr,
  input  logic [DMEM_LW-1:0] len,
  input  logic [DMEM_DW-1:0] fill_val,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [DMEM_LW-1:0] count,
  output logic               mem_en,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [DMEM_DW-1:0] mem_in,
  input  logic [DMEM_DW-1:0] mem_out
);

  localparam int WCW = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

  dma_state_t         state;
  logic               xfer_mode;
  logic [DMEM_AW-1:0] src_ptr;
  logic [DMEM_AW-1:0] dst_ptr;
  logic [DMEM_LW-1:0] xfer_len;
  logic [DMEM_DW-1:0] fill_word;
  logic [WCW-1:0]     wait_cnt;
  logic [DMEM_LW-1:0] count_inc;
  logic               last_word;

  assign count_inc = count + DMEM_LW'(1);
  assign last_word = (count_inc == xfer_len);

  // FSM, pointers and all outputs; outputs are set on the edge that enters
  // the state they belong to, so mem_in doubles as the copy data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      xfer_mode <= DMA_COPY;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      xfer_len  <= '0;
      fill_word <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_in    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mem_en <= 1'b0;
          done   <= 1'b0;
          if (start) begin
            xfer_mode <= mode;
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            xfer_len  <= len;
            fill_word <= fill_val;
            count     <= '0;
            busy      <= 1'b1;
            if (len == DMEM_LW'(0)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (mode == DMA_FILL) begin
              state    <= ST_WRITE;
              mem_en   <= 1'b1;
              mem_addr <= dst_addr;
              mem_in   <= fill_val;
            end else begin
              state    <= ST_READ;
              mem_addr <= src_addr;
            end
          end
        end

        ST_READ: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (READ_LAT > 0) begin
            state    <= ST_WAIT;
            wait_cnt <= WCW'(1);
          end else begin
            state    <= ST_WRITE;
            mem_in   <= mem_out;
            mem_en   <= 1'b1;
            mem_addr <= dst_ptr;
          end
        end

        ST_WAIT: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (wait_cnt == WCW'(READ_LAT)) begin
            state    <= ST_WRITE;
            mem_in   <= mem_out;
            mem_en   <= 1'b1;
            mem_addr <= dst_ptr;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end

        // The write in this cycle always commits, even when abort wins.
        ST_WRITE: begin
          count   <= count_inc;
          src_ptr <= ptr_inc(src_ptr);
          dst_ptr <= ptr_inc(dst_ptr);
          if (abort) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            mem_en <= 1'b0;
          end else if (last_word) begin
            state  <= ST_DONE;
            mem_en <= 1'b0;
            done   <= 1'b1;
          end else if (xfer_mode == DMA_FILL) begin
            mem_addr <= ptr_inc(dst_ptr);
            mem_in   <= fill_word;
          end else begin
            state    <= ST_READ;
            mem_en   <= 1'b0;
            mem_addr <= ptr_inc(src_ptr);
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          mem_en <= 1'b0;
        end

        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          mem_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Bench for dmem_copy_engine: two instances (combinational memory and a
// two-cycle read memory), a transfer-level model and a per-cycle comparator.
module tb_dmem_copy_engine;

  typedef struct packed {
    int          inst;
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i [2];
  logic        b_mode = 1'b0;
  logic [7:0]  b_src = 8'd0;
  logic [7:0]  b_dst = 8'd0;
  logic [8:0]  b_len = 9'd0;
  logic [15:0] b_fill = 16'd0;
  logic        b_abort = 1'b0;
  logic        busy_o [2];
  logic        done_o [2];
  logic [8:0]  count_o [2];
  logic        men [2];
  logic [7:0]  maddr [2];
  logic [15:0] min [2];
  logic [15:0] mout [2];

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  logic [15:0] p1, p2;
  logic        reload = 1'b0;

  logic [15:0] img [2][256];
  wr_t         wq [$];
  wr_t         w;
  int          cyc = 0;
  int          t0 [2];
  int          b_end [2];
  int          done_at [2];
  int          done_cyc [2];
  int          committed [2];
  bit          chk_on = 1'b0;
  int          tests = 0;
  int          fails = 0;
  int          m_lat, m_per, m_words;

  dmem_copy_engine #(.READ_LAT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start_i[0]), .mode(b_mode),
    .src_addr(b_src), .dst_addr(b_dst), .len(b_len), .fill_val(b_fill),
    .abort(b_abort), .busy(busy_o[0]), .done(done_o[0]), .count(count_o[0]),
    .mem_en(men[0]), .mem_addr(maddr[0]), .mem_in(min[0]), .mem_out(mout[0])
  );

  dmem_copy_engine #(.READ_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start_i[1]), .mode(b_mode),
    .src_addr(b_src), .dst_addr(b_dst), .len(b_len), .fill_val(b_fill),
    .abort(b_abort), .busy(busy_o[1]), .done(done_o[1]), .count(count_o[1]),
    .mem_en(men[1]), .mem_addr(maddr[1]), .mem_in(min[1]), .mem_out(mout[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input int i);
    return 16'(i + 1);
  endfunction

  // Data memories: combinational read for dut0, two-stage read for dut2.
  assign mout[0] = mem0[maddr[0]];
  assign mout[1] = p2;

  always @(posedge clk) begin
    if (reload) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= pat(i);
        mem1[i] <= pat(i);
      end
    end else begin
      if (men[0]) mem0[maddr[0]] <= min[0];
      if (men[1]) mem1[maddr[1]] <= min[1];
    end
    p1 <= mem1[maddr[1]];
    p2 <= p1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparator against the transfer model.
  always @(negedge clk) begin
    if (!reset && chk_on) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(cyc >= t0[k] && cyc <= b_end[k]));
        check($sformatf("done%0d", k), 32'(done_o[k]), 32'(cyc == done_at[k]));
        check($sformatf("count%0d", k), 32'(count_o[k]), 32'(committed[k]));
        if (done_o[k]) done_cyc[k] = cyc;
        if (men[k]) begin
          if (wq.size() == 0) begin
            check($sformatf("unexpected_write%0d", k), 32'(men[k]), 32'd0);
          end else begin
            w = wq.pop_front();
            check("write_inst", 32'(k), 32'(w.inst));
            check("write_addr", 32'(maddr[k]), 32'(w.a));
            check("write_data", 32'(min[k]), 32'(w.d));
            committed[k]++;
          end
        end
      end
    end
  end

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) img[k][i] = pat(i);
    @(posedge clk);
    #1 reload = 1'b0;
  endtask

  // Model the whole transfer up front, then issue start.
  task automatic launch(input int k, input logic md, input logic [7:0] src,
                        input logic [7:0] dst, input int n, input logic [15:0] fv,
                        input int abort_w);
    logic [7:0]  a, s;
    logic [15:0] v;
    wr_t         e;
    m_per   = md ? 1 : (2 + ((k == 1) ? 2 : 0));
    m_lat   = n * m_per;
    m_words = (abort_w > 0 && abort_w < n) ? abort_w : n;
    for (int i = 0; i < m_words; i++) begin
      a = dst + 8'(i);
      s = src + 8'(i);
      v = md ? fv : img[k][s];
      img[k][a] = v;
      e.inst = k; e.a = a; e.d = v;
      wq.push_back(e);
    end
    @(negedge clk);
    b_mode = md; b_src = src; b_dst = dst; b_len = 9'(n); b_fill = fv;
    start_i[k] = 1'b1;
    @(posedge clk);
    #1;
    start_i[k] = 1'b0;
    t0[k] = cyc;
    committed[k] = 0;
    if (abort_w > 0 && abort_w < n) begin
      b_end[k]   = t0[k] + abort_w * m_per - 1;
      done_at[k] = -1;
    end else begin
      b_end[k]   = t0[k] + m_lat;
      done_at[k] = t0[k] + m_lat;
    end
  endtask

  task automatic xfer(input int k, input logic md, input logic [7:0] src,
                      input logic [7:0] dst, input int n, input logic [15:0] fv,
                      input int abort_w, input int poke_c);
    int abort_c, errs;
    launch(k, md, src, dst, n, fv, abort_w);
    abort_c = abort_w * m_per - 1;
    for (int c = 0; c <= m_lat + 2; c++) begin
      @(negedge clk);
      b_abort = (abort_w > 0 && c == abort_c);
      if (poke_c > 0 && c == poke_c) begin
        start_i[k] = 1'b1;
        b_mode = ~md;
        b_len = 9'd1;
      end else begin
        start_i[k] = 1'b0;
      end
    end
    b_abort = 1'b0;
    start_i[k] = 1'b0;
    check("queue_drained", 32'(wq.size()), 32'd0);
    check("final_count", 32'(count_o[k]), 32'(m_words));
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (((k == 0) ? mem0[i] : mem1[i]) !== img[k][i]) errs++;
    check("mem_image", 32'(errs), 32'd0);
  endtask

  initial begin
    start_i[0] = 1'b0;
    start_i[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t0[k] = -100; b_end[k] = -100; done_at[k] = -100;
      done_cyc[k] = -100; committed[k] = 0;
    end
    #12;
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", 32'(busy_o[k]), 32'd0);
      check("rst_done", 32'(done_o[k]), 32'd0);
      check("rst_count", 32'(count_o[k]), 32'd0);
      check("rst_mem_en", 32'(men[k]), 32'd0);
      check("rst_mem_addr", 32'(maddr[k]), 32'h00);
      check("rst_mem_in", 32'(min[k]), 32'h0000);
    end
    @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;
    do_reload();

    // Copy 0..2 -> 0x10..0x12 with an ignored start while busy.
    xfer(0, 1'b0, 8'h00, 8'h10, 3, 16'h0000, 0, 2);
    check("copy_done_lat", 32'(done_cyc[0] - t0[0]), 32'd6);
    check("copy_m10", 32'(mem0[8'h10]), 32'h0001);
    check("copy_m11", 32'(mem0[8'h11]), 32'h0002);
    check("copy_m12", 32'(mem0[8'h12]), 32'h0003);
    check("copy_count", 32'(count_o[0]), 32'd3);

    // Overlapping forward copy.
    do_reload();
    xfer(0, 1'b0, 8'h00, 8'h01, 2, 16'h0000, 0, 0);
    check("ovl_m1", 32'(mem0[8'h01]), 32'h0001);
    check("ovl_m2", 32'(mem0[8'h02]), 32'h0001);

    // Zero-length transfer.
    xfer(0, 1'b0, 8'h00, 8'h30, 0, 16'h0000, 0, 0);
    check("len0_done_lat", 32'(done_cyc[0] - t0[0]), 32'd0);
    check("len0_count", 32'(count_o[0]), 32'd0);

    // Fill that wraps through 0xFF -> 0x00.
    xfer(0, 1'b1, 8'h00, 8'hFE, 4, 16'hABCD, 0, 0);
    check("fill_done_lat", 32'(done_cyc[0] - t0[0]), 32'd4);
    check("fill_mFE", 32'(mem0[8'hFE]), 32'hABCD);
    check("fill_mFF", 32'(mem0[8'hFF]), 32'hABCD);
    check("fill_m00", 32'(mem0[8'h00]), 32'hABCD);
    check("fill_m01", 32'(mem0[8'h01]), 32'hABCD);
    check("fill_m02", 32'(mem0[8'h02]), 32'h0001);

    // Abort during the third write of an 8-word fill.
    xfer(0, 1'b1, 8'h00, 8'h80, 8, 16'h1234, 3, 0);
    check("abort_count", 32'(count_o[0]), 32'd3);
    check("abort_m82", 32'(mem0[8'h82]), 32'h1234);
    check("abort_m83", 32'(mem0[8'h83]), 32'h0084);

    // Asynchronous reset in the middle of a copy.
    launch(0, 1'b0, 8'h20, 8'h60, 5, 16'h0000, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    wq.delete();
    b_end[0] = -100; done_at[0] = -100;
    committed[0] = 0; committed[1] = 0;
    #1;
    check("mid_rst_busy", 32'(busy_o[0]), 32'd0);
    check("mid_rst_done", 32'(done_o[0]), 32'd0);
    check("mid_rst_count", 32'(count_o[0]), 32'd0);
    check("mid_rst_mem_en", 32'(men[0]), 32'd0);
    check("mid_rst_mem_addr", 32'(maddr[0]), 32'h00);
    check("mid_rst_mem_in", 32'(min[0]), 32'h0000);
    #4 reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_m62", 32'(mem0[8'h62]), 32'h0063);

    // Copy through the two-cycle read memory.
    do_reload();
    xfer(1, 1'b0, 8'h00, 8'h10, 3, 16'h0000, 0, 0);
    check("rl2_done_lat", 32'(done_cyc[1] - t0[1]), 32'd12);
    check("rl2_m10", 32'(mem1[8'h10]), 32'h0001);
    check("rl2_m12", 32'(mem1[8'h12]), 32'h0003);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
